// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host link: transmitter state encoding,
// keyboard command/response bytes and default timing constants.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int unsigned DEF_CLK_FREQ_HZ    = 100_000_000;
    localparam int unsigned DEF_INHIBIT_CYCLES = 10_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200_000;
    localparam int unsigned DEF_FILTER_LEN     = 8;

    // Odd parity: the nine transmitted data+parity bits carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 line.
// The level output only moves after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= 2'b11;
            cnt     <= '0;
            level_q <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level_q) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level_q <= sync[1];
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain enables, done/err pulses).
// Optional device-clock watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    // Filter delay must stay far below the ~30 us minimum PS/2 half-period.
    if (FILTER_LEN + 2 >= CLK_FREQ_HZ / 33_333) begin : g_filter_too_slow
        $error("ps2_host_tx: FILTER_LEN too long for CLK_FREQ_HZ");
    end
    if (TIMEOUT_CYCLES == 0 || INHIBIT_CYCLES == 0) begin : g_bad_timing
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    ps2_tx_state_e    state, state_next;
    logic             clk_filt, data_filt, clk_prev, fall;
    logic [INH_W-1:0] inh_cnt;
    logic [9:0]       frame;
    logic [3:0]       bit_cnt;
    logic             data_oe_q, ack_ok, done_q, err_q;
    logic             accept, timeout, wd_active;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_in),
        .level (data_filt)
    );

    assign fall      = clk_prev & ~clk_filt;
    assign wd_active = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_RELEASE);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign timeout = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (!wd_active || fall || (state_next != state)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    accept     = 1'b1;
                    state_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: if (inh_cnt == INH_W'(1)) state_next = ST_REQ;
            ST_REQ:     state_next = ST_SHIFT;
            ST_SHIFT:   if (fall && (bit_cnt == 4'd9)) state_next = ST_ACK;
            ST_ACK:     if (fall) state_next = ST_RELEASE;
            ST_RELEASE: if (clk_filt && data_filt) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (timeout) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            clk_prev  <= 1'b1;
            inh_cnt   <= '0;
            frame     <= '0;
            bit_cnt   <= '0;
            data_oe_q <= 1'b0;
            ack_ok    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_next;
            clk_prev <= clk_filt;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        frame   <= {1'b1, odd_parity(tx_data), tx_data};
                        inh_cnt <= INH_W'(INHIBIT_CYCLES);
                        bit_cnt <= '0;
                    end
                end
                ST_INHIBIT: begin
                    inh_cnt <= inh_cnt - 1'b1;
                    if (state_next == ST_REQ) data_oe_q <= 1'b1;
                end
                ST_SHIFT: begin
                    // Frame is consumed LSB first; the stop bit (1) releases data.
                    if (fall) begin
                        data_oe_q <= ~frame[0];
                        frame     <= {1'b0, frame[9:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                ST_ACK: if (fall) ack_ok <= ~data_filt;
                ST_RELEASE: begin
                    if ((state_next == ST_IDLE) && !timeout) begin
                        done_q <= ack_ok;
                        err_q  <= ~ack_ok;
                    end
                end
                default: ;
            endcase
            if (timeout) begin
                data_oe_q <= 1'b0;
                err_q     <= 1'b1;
            end
        end
    end

    assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = (state == ST_IDLE);
    assign tx_busy     = ~tx_ready;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule
